// File: rtl/n64_pif_pkg.sv
// n64_pif_pkg: shared encodings for the RCP->PIF serial initiator.
// Transfer types, FSM states and serial bit counts.
package n64_pif_pkg;

   typedef enum logic [1:0] {
      CMD_RD4  = 2'd0,
      CMD_RD64 = 2'd1,
      CMD_WR4  = 2'd2,
      CMD_WR64 = 2'd3
   } cmd_type_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      HDR,
      WAIT_ACK,
      RD_DATA,
      WR_START,
      WR_DATA,
      FINISH
   } state_e;

   localparam int HDR_BITS   = 11;
   localparam int WORD_BITS  = 32;
   localparam int BURST_BITS = 512;

   function automatic logic is_write(input cmd_type_e t);
      return t[1];
   endfunction

   // index of the final payload bit for a transfer type
   function automatic logic [8:0] last_bit(input cmd_type_e t);
      return t[0] ? 9'(BURST_BITS - 1) : 9'(WORD_BITS - 1);
   endfunction

endpackage

// File: rtl/n64_pif_shift32.sv
// n64_pif_shift32: 32-bit shifter, parallel load, serial in/out.
// cap presents the word including the bit currently on sin.
module n64_pif_shift32 (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        load,
   input  logic        shift,
   input  logic        sin,
   input  logic [31:0] load_data,
   output logic        sout,
   output logic [31:0] cap
);

   logic [31:0] sh_d;
   logic [31:0] sh_q;

   // load has priority over shift; MSB leaves first
   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = load_data;
      end else if (shift) begin
         sh_d = {sh_q[30:0], sin};
      end
   end

   // shift register state
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign sout = sh_q[31];
   assign cap  = {sh_q[30:0], sin};

endmodule

// File: rtl/n64_rcp_pif_initiator.sv
// n64_rcp_pif_initiator: RCP-side serial transaction initiator to PIF.
// Optional ack timeout: define N64_PIF_INIT_TIMEOUT_EN.
module n64_rcp_pif_initiator
   import n64_pif_pkg::*;
#(
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic        n64_clk,
   input  logic        reset_l,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [8:0]  cmd_addr,
   output logic [8:0]  wr_addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic [3:0]  rd_index,
   output logic        done,
   output logic        err_timeout,
   output logic        rcp_pif_out,
   input  logic        pif_rcp_in
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam int WAIT_W = (TW < 2) ? 2 : TW;

   state_e      state_d, state_q;
   cmd_type_e   type_d, type_q;
   logic [10:0] hdr_d, hdr_q;
   logic [8:0]  cnt_d, cnt_q;
   logic [WAIT_W-1:0] wait_d, wait_q;
   logic        line_d, line_q;
   logic        ready_d, ready_q;
   logic [8:0]  wr_addr_d, wr_addr_q;
   logic [31:0] rd_data_d, rd_data_q;
   logic        rd_valid_d, rd_valid_q;
   logic [3:0]  rd_index_d, rd_index_q;
   logic        done_d, done_q;
   logic        s1_q, s2_q;
   logic        sh_load, sh_shift;
   logic        sh_sout;
   logic [31:0] sh_cap;
   logic        ack, flushed;

`ifdef N64_PIF_INIT_TIMEOUT_EN
   logic        err_d, err_q;
`endif

   assign ack     = ~s2_q;
   assign flushed = (wait_q >= WAIT_W'(2));

   n64_pif_shift32 u_shift (
      .clk       (n64_clk),
      .rst_l     (reset_l),
      .load      (sh_load),
      .shift     (sh_shift),
      .sin       (s2_q),
      .load_data ({wr_data[30:0], 1'b0}),
      .sout      (sh_sout),
      .cap       (sh_cap)
   );

   // two-flop synchronizer for the inbound PIF line
   always_ff @(posedge n64_clk or negedge reset_l) begin
      if (!reset_l) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= pif_rcp_in;
         s2_q <= s1_q;
      end
   end

   // next state and next registered outputs
   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      hdr_d      = hdr_q;
      cnt_d      = cnt_q;
      wait_d     = wait_q;
      line_d     = 1'b1;
      wr_addr_d  = wr_addr_q;
      rd_data_d  = rd_data_q;
      rd_index_d = rd_index_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      sh_load    = 1'b0;
      sh_shift   = 1'b0;
`ifdef N64_PIF_INIT_TIMEOUT_EN
      err_d      = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && ready_q) begin
               state_d   = START;
               type_d    = cmd_type_e'(cmd_type);
               hdr_d     = {cmd_type, cmd_addr};
               wr_addr_d = cmd_addr;
               line_d    = 1'b0;
            end
         end
         START: begin
            line_d  = hdr_q[10];
            hdr_d   = {hdr_q[9:0], 1'b0};
            cnt_d   = '0;
            state_d = HDR;
         end
         HDR: begin
            if (cnt_q == 9'(HDR_BITS - 1)) begin
               state_d = WAIT_ACK;
               wait_d  = '0;
            end else begin
               line_d = hdr_q[10];
               hdr_d  = {hdr_q[9:0], 1'b0};
               cnt_d  = cnt_q + 9'd1;
            end
         end
         WAIT_ACK: begin
            if (flushed && ack) begin
               cnt_d = '0;
               if (is_write(type_q)) begin
                  state_d = WR_START;
                  line_d  = 1'b0;
               end else begin
                  state_d = RD_DATA;
               end
`ifdef N64_PIF_INIT_TIMEOUT_EN
            end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
`else
            end else if (!flushed) begin
               wait_d = wait_q + 1'b1;
`endif
            end
         end
         RD_DATA: begin
            sh_shift = 1'b1;
            if (cnt_q[4:0] == 5'd31) begin
               rd_valid_d = 1'b1;
               rd_data_d  = sh_cap;
               rd_index_d = cnt_q[8:5];
            end
            if (cnt_q == last_bit(type_q)) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         WR_START: begin
            sh_load   = 1'b1;
            line_d    = wr_data[31];
            wr_addr_d = wr_addr_q + 9'd1;
            cnt_d     = '0;
            state_d   = WR_DATA;
         end
         WR_DATA: begin
            if (cnt_q == last_bit(type_q)) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 9'd1;
               if (cnt_q[4:0] == 5'd31) begin
                  sh_load   = 1'b1;
                  line_d    = wr_data[31];
                  wr_addr_d = wr_addr_q + 9'd1;
               end else begin
                  sh_shift = 1'b1;
                  line_d   = sh_sout;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   // FSM state and registered outputs
   always_ff @(posedge n64_clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q    <= IDLE;
         type_q     <= CMD_RD4;
         hdr_q      <= '0;
         cnt_q      <= '0;
         wait_q     <= '0;
         line_q     <= 1'b1;
         ready_q    <= 1'b1;
         wr_addr_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_index_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         hdr_q      <= hdr_d;
         cnt_q      <= cnt_d;
         wait_q     <= wait_d;
         line_q     <= line_d;
         ready_q    <= ready_d;
         wr_addr_q  <= wr_addr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_index_q <= rd_index_d;
         done_q     <= done_d;
      end
   end

`ifdef N64_PIF_INIT_TIMEOUT_EN
   // ack timeout strobe
   always_ff @(posedge n64_clk or negedge reset_l) begin
      if (!reset_l) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_timeout = err_q;
`else
   assign err_timeout = 1'b0;
`endif

   assign cmd_ready   = ready_q;
   assign wr_addr     = wr_addr_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign rd_index    = rd_index_q;
   assign done        = done_q;
   assign rcp_pif_out = line_q;

endmodule

// File: tb/tb_n64_rcp_pif_initiator.sv
// tb_n64_rcp_pif_initiator: self-checking bench with a PIF line model.
// Vector table of transactions plus reset/timeout/idle sequences.
module tb_n64_rcp_pif_initiator;

   localparam int TMO = 1023;

   logic        n64_clk = 1'b0;
   logic        reset_l = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_type = '0;
   logic [8:0]  cmd_addr = '0;
   logic [31:0] wr_data;
   logic        pif_rcp_in = 1'b1;
   logic        cmd_ready;
   logic [8:0]  wr_addr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [3:0]  rd_index;
   logic        done;
   logic        err_timeout;
   logic        rcp_pif_out;

   always #5 n64_clk = ~n64_clk;

   n64_rcp_pif_initiator #(.ACK_TIMEOUT(TMO)) dut (
      .n64_clk     (n64_clk),
      .reset_l     (reset_l),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_type    (cmd_type),
      .cmd_addr    (cmd_addr),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_index    (rd_index),
      .done        (done),
      .err_timeout (err_timeout),
      .rcp_pif_out (rcp_pif_out),
      .pif_rcp_in  (pif_rcp_in)
   );

   // local write buffer: data follows wr_addr by one cycle
   logic [31:0] mem [512];
   always @(posedge n64_clk) wr_data <= mem[wr_addr];

   // output monitors
   logic [31:0] rdq_data [$];
   logic [3:0]  rdq_idx [$];
   int done_cnt = 0;
   int err_cnt = 0;
   always @(negedge n64_clk) begin
      if (rd_valid) begin
         rdq_data.push_back(rd_data);
         rdq_idx.push_back(rd_index);
      end
      if (done) done_cnt++;
      if (err_timeout) err_cnt++;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  t;
      logic [8:0]  a;
      int          dly;
      bit          glitch;
      bit          poke;
      bit          rnd;
      logic [31:0] d0;
      logic [10:0] exp_hdr;
   } vec_t;

   vec_t vecs [12];

   task automatic run_txn(input vec_t v);
      int n, dbase, rbase, c;
      logic [10:0] hdr;
      logic [31:0] w [16];
      logic [31:0] got;
      logic [8:0]  ad;
      n = v.t[0] ? 16 : 1;
      dbase = done_cnt;
      rbase = rdq_data.size();
      for (int k = 0; k < 16; k++)
         w[k] = v.rnd ? $urandom : v.d0 + 32'(k);
      @(negedge n64_clk);
      chk("idle_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_type  = v.t;
      cmd_addr  = v.a;
      @(negedge n64_clk);
      cmd_valid = 1'b0;
      chk("start_bit", rcp_pif_out, 0);
      chk("wr_addr_load", wr_addr, v.a);
      chk("busy_ready", cmd_ready, 0);
      if (v.glitch) pif_rcp_in = 1'b0;
      hdr = '0;
      for (int i = 0; i < 11; i++) begin
         @(negedge n64_clk);
         hdr = {hdr[9:0], rcp_pif_out};
      end
      chk("header", hdr, v.exp_hdr);
      for (int d = 1; d <= v.dly; d++) begin
         @(negedge n64_clk);
         if (d == 1) begin
            pif_rcp_in = 1'b1;
            chk("line_release", rcp_pif_out, 1);
         end
         if (v.poke) begin
            cmd_valid = 1'b1;
            cmd_type  = ~v.t;
            cmd_addr  = ~v.a;
         end
         if (d == v.dly) begin
            if (v.poke)
               chk("wait_forever", {cmd_ready, err_timeout}, 0);
            pif_rcp_in = 1'b0;
            cmd_valid  = 1'b0;
         end
      end
      if (!v.t[1]) begin
         for (int b = 0; b < 32 * n; b++) begin
            @(negedge n64_clk);
            pif_rcp_in = w[b / 32][31 - (b % 32)];
         end
         @(negedge n64_clk);
         pif_rcp_in = 1'b1;
      end else begin
         c = 0;
         do begin
            @(negedge n64_clk);
            pif_rcp_in = 1'b1;
            c++;
         end while (rcp_pif_out !== 1'b0 && c < 10);
         chk("wr_start_bit", rcp_pif_out, 0);
         for (int k = 0; k < n; k++) begin
            got = '0;
            for (int b = 0; b < 32; b++) begin
               @(negedge n64_clk);
               got = {got[30:0], rcp_pif_out};
            end
            ad = v.a + 9'(k);
            chk("wr_word", got, mem[ad]);
         end
      end
      c = 0;
      while (done_cnt == dbase && c < 20) begin
         @(negedge n64_clk);
         c++;
      end
      @(negedge n64_clk);
      @(negedge n64_clk);
      chk("done_once", done_cnt - dbase, 1);
      chk("rd_count", rdq_data.size() - rbase, v.t[1] ? 0 : n);
      if (!v.t[1]) begin
         for (int k = 0; k < n; k++) begin
            if (rbase + k < rdq_data.size()) begin
               chk("rd_data", rdq_data[rbase + k], w[k]);
               chk("rd_index", rdq_idx[rbase + k], k);
            end
         end
      end else begin
         chk("wr_addr_end", wr_addr, 9'(v.a + 9'(n)));
      end
      chk("back_idle", {cmd_ready, rcp_pif_out}, 2'b11);
      c = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge n64_clk);
         if (!rcp_pif_out) c++;
      end
      chk("no_queued", c, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rbase, dbase, ebase, c;
      logic [31:0] w [4];
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      mem[9'h1FF] = 32'h12345678;

      vecs[0] = '{t:2'd0, a:9'h1F0, dly:3, glitch:0, poke:0, rnd:0,
                  d0:32'hDEADBEEF, exp_hdr:11'b00_111110000};
      vecs[1] = '{t:2'd1, a:9'h000, dly:2, glitch:0, poke:0, rnd:0,
                  d0:32'h0, exp_hdr:11'b01_000000000};
      vecs[2] = '{t:2'd2, a:9'h1FF, dly:3, glitch:0, poke:0, rnd:0,
                  d0:32'h0, exp_hdr:11'b10_111111111};
      vecs[3] = '{t:2'd3, a:9'h1F8, dly:4, glitch:0, poke:0, rnd:0,
                  d0:32'h0, exp_hdr:11'b11_111111000};
      vecs[4] = '{t:2'd0, a:9'h055, dly:1, glitch:1, poke:0, rnd:1,
                  d0:32'h0, exp_hdr:11'b00_001010101};
      vecs[5] = '{t:2'd2, a:9'h0AA, dly:40, glitch:0, poke:1, rnd:0,
                  d0:32'h0, exp_hdr:11'b10_010101010};
      for (int i = 6; i < 12; i++) begin
         vecs[i].t = 2'($urandom_range(0, 3));
         vecs[i].a = 9'($urandom);
         vecs[i].dly = $urandom_range(1, 6);
         vecs[i].glitch = 1'($urandom_range(0, 1));
         vecs[i].poke = 1'b0;
         vecs[i].rnd = 1'b1;
         vecs[i].d0 = '0;
         vecs[i].exp_hdr = {vecs[i].t, vecs[i].a};
      end

      repeat (3) @(negedge n64_clk);
      chk("rst_line", rcp_pif_out, 1);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_index", rd_index, 0);
      chk("rst_wr_addr", wr_addr, 0);
      reset_l = 1'b1;

      for (int i = 0; i < 12; i++) run_txn(vecs[i]);

      // inbound lows while idle must not start anything
      rbase = rdq_data.size();
      @(negedge n64_clk);
      pif_rcp_in = 1'b0;
      repeat (6) @(negedge n64_clk);
      pif_rcp_in = 1'b1;
      repeat (4) @(negedge n64_clk);
      chk("idle_glitch_ready", cmd_ready, 1);
      chk("idle_glitch_line", rcp_pif_out, 1);
      chk("idle_glitch_rd", rdq_data.size() - rbase, 0);

`ifdef N64_PIF_INIT_TIMEOUT_EN
      ebase = err_cnt;
      dbase = done_cnt;
      @(negedge n64_clk);
      cmd_valid = 1'b1;
      cmd_type  = 2'd0;
      cmd_addr  = 9'h077;
      @(negedge n64_clk);
      cmd_valid = 1'b0;
      repeat (11) @(negedge n64_clk);
      c = 0;
      @(negedge n64_clk);
      while (err_timeout !== 1'b1 && c < 1100) begin
         @(negedge n64_clk);
         c++;
      end
      chk("tmo_cycle", c, TMO);
      chk("tmo_ready", cmd_ready, 1);
      @(negedge n64_clk);
      chk("tmo_ready_next", cmd_ready, 1);
      chk("tmo_strobe_len", err_timeout, 0);
      chk("tmo_no_done", done_cnt - dbase, 0);
      chk("tmo_count", err_cnt - ebase, 1);
`else
      chk("err_tied_low", err_cnt, 0);
`endif

      // reset while receiving bit 100 of a 64B read
      rbase = rdq_data.size();
      dbase = done_cnt;
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      @(negedge n64_clk);
      cmd_valid = 1'b1;
      cmd_type  = 2'd1;
      cmd_addr  = 9'h0C3;
      @(negedge n64_clk);
      cmd_valid = 1'b0;
      repeat (11) @(negedge n64_clk);
      repeat (2) @(negedge n64_clk);
      pif_rcp_in = 1'b0;
      for (int b = 0; b <= 102; b++) begin
         @(negedge n64_clk);
         pif_rcp_in = w[b / 32][31 - (b % 32)];
      end
      reset_l = 1'b0;
      #1;
      chk("arst_line", rcp_pif_out, 1);
      chk("arst_ready", cmd_ready, 1);
      chk("arst_rd_count", rdq_data.size() - rbase, 3);
      for (int k = 0; k < 3; k++)
         chk("arst_rd_word", rdq_data[rbase + k], w[k]);
      repeat (3) begin
         @(negedge n64_clk);
         pif_rcp_in = 1'($urandom);
      end
      reset_l = 1'b1;
      pif_rcp_in = 1'b1;
      repeat (40) @(negedge n64_clk);
      chk("arst_no_rd", rdq_data.size() - rbase, 3);
      chk("arst_no_done", done_cnt - dbase, 0);
      chk("arst_idle", {cmd_ready, rcp_pif_out}, 2'b11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
